// File: rtl/mixed_op_datapath.sv
// Registered mixed-operation datapath: arithmetic, logic, rotate, popcount,
// running accumulators and input history on a 376-bit bus.
// Optional build macro MIXED_OP_SAT_ACC_EN makes the accumulator saturate.
module mixed_op_datapath (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   wire0,
  input  logic [21:0]  wire1,
  input  logic [7:0]   wire2,
  input  logic [17:0]  wire3,
  output logic [375:0] y
);

  localparam int HIST_W = 54;
  localparam int HIST_N = 4;

  logic [31:0]              r_acc;
  logic [15:0]              r_cnt;
  logic [22:0]              r_sum;
  logic [14:0]              r_prod;
  logic [21:0]              r_xr;
  logic [21:0]              r_rot;
  logic [7:0]               r_mx;
  logic [5:0]               r_pop;
  logic [15:0]              r_chk;
  logic [HIST_N*HIST_W-1:0] r_hist;

  logic signed [14:0] w_prod;
  logic [31:0]        w_addend;
  logic [31:0]        w_acc_next;
  logic [22:0]        w_sum;
  logic [21:0]        w_xr;
  logic [4:0]         w_rot_amt;
  logic [43:0]        w_rot_dbl;
  logic [21:0]        w_rot;
  logic [7:0]         w_mx;
  logic [45:0]        w_pop_src;
  logic [5:0]         w_pop;
  logic [HIST_W-1:0]  w_word;

  // A is widened with a zero sign bit so the product stays a signed multiply.
  assign w_prod   = $signed(wire2) * $signed({1'b0, wire0});
  assign w_addend = {{17{w_prod[14]}}, w_prod};

`ifdef MIXED_OP_SAT_ACC_EN
  logic [32:0] w_acc_wide;
  assign w_acc_wide = {r_acc[31], r_acc} + {w_addend[31], w_addend};
  always_comb begin
    w_acc_next = w_acc_wide[31:0];
    if (w_acc_wide[32:31] == 2'b01)
      w_acc_next = 32'h7FFF_FFFF;
    else if (w_acc_wide[32:31] == 2'b10)
      w_acc_next = 32'h8000_0000;
  end
`else
  assign w_acc_next = r_acc + w_addend;
`endif

  assign w_sum = {1'b0, wire1} + {5'd0, wire3};
  assign w_xr  = wire1 ^ {wire3, wire0[3:0]};

  // Rotate by shifting a doubled copy; upper half is the rotated word.
  assign w_rot_amt = 5'(wire0 % 6'd22);
  assign w_rot_dbl = {wire1, wire1} << w_rot_amt;
  assign w_rot     = w_rot_dbl[43:22];

  assign w_mx = ($signed(wire2) >= $signed(wire3[7:0])) ? wire2 : wire3[7:0];

  assign w_pop_src = {wire3, wire1, wire0};
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 46; i++)
      w_pop = w_pop + 6'(w_pop_src[i]);
  end

  assign w_word = {wire3, wire2, wire1, wire0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_prod <= '0;
      r_xr   <= '0;
      r_rot  <= '0;
      r_mx   <= '0;
      r_pop  <= '0;
      r_chk  <= '0;
      r_hist <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt + 16'd1;
      r_sum  <= w_sum;
      r_prod <= w_prod;
      r_xr   <= w_xr;
      r_rot  <= w_rot;
      r_mx   <= w_mx;
      r_pop  <= w_pop;
      r_chk  <= r_chk + wire3[15:0];
      r_hist <= {r_hist[(HIST_N-1)*HIST_W-1:0], w_word};
    end
  end

  assign y = {r_acc, r_cnt, r_sum, r_prod, r_xr, r_rot, r_mx, r_pop, r_chk, r_hist};

endmodule

// File: tb/tb_mixed_op_datapath.sv
// Scoreboard bench for mixed_op_datapath: random and directed stimulus vs. an
// arithmetic reference model; a negedge monitor pops expectations and compares.
module tb_mixed_op_datapath;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   wire0;
  logic [21:0]  wire1;
  logic [7:0]   wire2;
  logic [17:0]  wire3;
  logic [375:0] y;

  int checks   = 0;
  int failures = 0;

  logic [375:0] exp_q[$];

  // Reference model state
  logic [31:0] m_acc;
  logic [15:0] m_cnt;
  logic [15:0] m_chk;
  logic [53:0] m_h[4];

  mixed_op_datapath dut (
    .clk(clk), .rst_n(rst_n), .wire0(wire0), .wire1(wire1),
    .wire2(wire2), .wire3(wire3), .y(y)
  );

  always #5 clk = ~clk;

  string fname[10] = '{"acc","cnt","sum","prod","xr","rot","mx","pop","chk","hist"};
  int    flsb[10]  = '{344, 328, 305, 290, 268, 246, 238, 232, 216, 0};
  int    fwid[10]  = '{32, 16, 23, 15, 22, 22, 8, 6, 16, 216};

  function automatic logic [375:0] field(input logic [375:0] v, input int k);
    logic [375:0] one;
    one = 376'd1;
    return (v >> flsb[k]) & ((one << fwid[k]) - one);
  endfunction

  task automatic check(input string name, input logic [375:0] act, input logic [375:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  // Monitor: each cycle with a pending expectation, compare every field.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [375:0] e;
      e = exp_q.pop_front();
      for (int k = 0; k < 10; k++)
        check(fname[k], field(y, k), field(e, k));
    end
  end

  // Reference model: advance state for one edge and return the expected bus.
  function automatic logic [375:0] model(input logic rst, input logic [5:0] a,
      input logic [21:0] b, input logic [7:0] c, input logic [17:0] d);
    int p, sum_i, amt;
    longint s;
    logic signed [7:0] cs, ds;
    logic [14:0] e_prod;
    logic [22:0] e_sum;
    logic [21:0] e_xr, e_rot;
    logic [7:0]  e_mx;
    logic [5:0]  e_pop;
    if (!rst) begin
      m_acc = 0; m_cnt = 0; m_chk = 0;
      for (int i = 0; i < 4; i++) m_h[i] = 0;
      return '0;
    end
    cs = c; ds = d[7:0];
    p = int'(cs) * int'(a);
    e_prod = p[14:0];
    s = longint'($signed(m_acc)) + longint'(p);
`ifdef MIXED_OP_SAT_ACC_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    m_acc = s[31:0];
    m_cnt = m_cnt + 1;
    sum_i = int'(b) + int'(d);
    e_sum = sum_i[22:0];
    e_xr  = b ^ {d, a[3:0]};
    amt = int'(a) % 22;
    e_rot = '0;
    for (int i = 0; i < 22; i++) e_rot[(i + amt) % 22] = b[i];
    e_mx  = (int'(cs) >= int'(ds)) ? c : d[7:0];
    e_pop = 6'($countones({d, b, a}));
    m_chk = m_chk + d[15:0];
    for (int i = 3; i > 0; i--) m_h[i] = m_h[i-1];
    m_h[0] = {d, c, b, a};
    return {m_acc, m_cnt, e_sum, e_prod, e_xr, e_rot, e_mx, e_pop, m_chk,
            m_h[3], m_h[2], m_h[1], m_h[0]};
  endfunction

  task automatic step(input logic rst, input logic [5:0] a, input logic [21:0] b,
                      input logic [7:0] c, input logic [17:0] d);
    rst_n = rst; wire0 = a; wire1 = b; wire2 = c; wire3 = d;
    @(posedge clk);
    exp_q.push_back(model(rst, a, b, c, d));
    @(negedge clk);
  endtask

  task automatic rstep(input logic rst);
    step(rst, 6'($urandom), 22'($urandom), 8'($urandom), 18'($urandom));
  endtask

  logic [53:0] w[5];

  initial begin
    rst_n = 1'b0; wire0 = '0; wire1 = '0; wire2 = '0; wire3 = '0;
    @(negedge clk);

    // Reset with random inputs
    rstep(1'b0); rstep(1'b0);
    check("reset_y", y, 376'd0);

    // Single word just after reset
    step(1'b1, 6'h03, 22'h000010, 8'hFE, 18'h00005);
    check("sw_acc",  field(y, 0), 376'(32'hFFFFFFFA));
    check("sw_cnt",  field(y, 1), 376'd1);
    check("sw_sum",  field(y, 2), 376'h15);
    check("sw_prod", field(y, 3), 376'h7FFA);
    check("sw_xr",   field(y, 4), 376'h43);
    check("sw_rot",  field(y, 5), 376'h80);
    check("sw_mx",   field(y, 6), 376'h05);
    check("sw_pop",  field(y, 7), 376'd5);
    check("sw_chk",  field(y, 8), 376'h5);
    check("sw_hist", field(y, 9), 376'({18'h00005, 8'hFE, 22'h000010, 6'h03}));

    // Rotate boundaries
    step(1'b1, 6'h3F, 22'h200001, 8'h11, 18'h0);
    check("rot_19", field(y, 5), 376'h0C0000);
    step(1'b1, 6'h16, 22'h200001, 8'h11, 18'h0);
    check("rot_0", field(y, 5), 376'h200001);

    // Random traffic including negative C and signed max ties
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 3) begin
        logic [7:0] t;
        t = 8'($urandom);
        step(1'b1, 6'($urandom), 22'($urandom), t, {10'($urandom), t});
      end else begin
        rstep(1'b1);
      end
    end

    // History: five words after a mid-stream reset
    rstep(1'b0);
    for (int i = 0; i < 5; i++) begin
      w[i] = {18'($urandom), 8'($urandom), 22'($urandom), 6'($urandom)};
      step(1'b1, w[i][5:0], w[i][27:6], w[i][35:28], w[i][53:36]);
    end
    check("hist5", field(y, 9), 376'({w[1], w[2], w[3], w[4]}));
    check("cnt5",  field(y, 1), 376'd5);

    // Accumulator under the largest negative addend, then reset
    for (int i = 0; i < 64; i++) step(1'b1, 6'h3F, 22'($urandom), 8'h80, 18'($urandom));
    rstep(1'b0);
    check("acc_rst", field(y, 0), 376'd0);

    // Counter and checksum wrap
    for (int i = 0; i < 65536; i++) step(1'b1, 6'($urandom), 22'($urandom), 8'($urandom), 18'h0FFFF);
    check("cnt_wrap", field(y, 1), 376'd0);
    check("chk_wrap", field(y, 8), 376'd0);

    @(posedge clk);
    check("queue_drained", 376'(exp_q.size()), 376'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
